// File: rtl/md5_cand_gen.sv
// BCD password candidate generator: walks [start_bcd, end_bcd] by a decimal stride and
// emits each value as ASCII digits on a valid/ready interface for the md5 core.
module md5_cand_gen #(
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_DIGITS*4-1:0] start_bcd,
    input  logic [NUM_DIGITS*4-1:0] end_bcd,
    input  logic [3:0]              stride,
    input  logic                    stop,
    output logic                    cand_valid,
    input  logic                    cand_ready,
    output logic [NUM_DIGITS*8-1:0] cand_att,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             count
);

    localparam int unsigned BcdW = NUM_DIGITS * 4;
    localparam int unsigned AscW = NUM_DIGITS * 8;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [BcdW-1:0] cur_q, cur_d;
    logic [BcdW-1:0] end_q, end_d;
    logic [3:0]      stride_q, stride_d;
    logic [31:0]     count_q, count_d;
    logic            err_q, err_d;
    logic [AscW-1:0] att_q, att_d;

    logic [BcdW-1:0] sum_bcd;
    logic            sum_carry;
    logic            xfer;

    function automatic logic has_bad_digit(input logic [BcdW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [AscW-1:0] to_ascii(input logic [BcdW-1:0] v);
        logic [AscW-1:0] a;
        a = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            a[i*8 +: 8] = {4'h3, v[i*4 +: 4]};
        end
        return a;
    endfunction

    // Ripple BCD add of the stride into the least significant digit; the final carry
    // marks overflow past the all-nines value.
    always_comb begin
        logic [4:0] dsum;
        logic       c;
        dsum    = '0;
        c       = 1'b0;
        sum_bcd = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            dsum = 5'(cur_q[i*4 +: 4]) + 5'(c);
            if (i == 0) dsum = dsum + 5'(stride_q);
            if (dsum >= 5'd10) begin
                dsum = dsum - 5'd10;
                c    = 1'b1;
            end else begin
                c = 1'b0;
            end
            sum_bcd[i*4 +: 4] = dsum[3:0];
        end
        sum_carry = c;
    end

    assign xfer = (state_q == StRun) && cand_ready;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        end_d    = end_q;
        stride_d = stride_q;
        count_d  = count_q;
        err_d    = err_q;
        att_d    = att_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    cur_d    = start_bcd;
                    end_d    = end_bcd;
                    stride_d = (stride == 4'd0) ? 4'd1 : stride;
                    count_d  = '0;
                    err_d    = has_bad_digit(start_bcd) || has_bad_digit(end_bcd);
                    if (err_d) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                        att_d   = to_ascii(start_bcd);
                    end
                end
            end
            StRun: begin
                if (xfer) begin
                    if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
                    if (stop || (cur_q >= end_q) || sum_carry) begin
                        state_d = StDone;
                    end else begin
                        cur_d = sum_bcd;
                        att_d = to_ascii(sum_bcd);
                    end
                end else if (stop) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cur_q    <= '0;
            end_q    <= '0;
            stride_q <= 4'd1;
            count_q  <= '0;
            err_q    <= 1'b0;
            att_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            end_q    <= end_d;
            stride_q <= stride_d;
            count_q  <= count_d;
            err_q    <= err_d;
            att_q    <= att_d;
        end
    end

    assign cand_valid = (state_q == StRun);
    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign cand_att   = att_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_md5_cand_gen.sv
// Directed bench for md5_cand_gen: expected candidates come from an integer decimal model
// and are queued at start, then popped by a monitor on each accepted transfer.
module tb_md5_cand_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_bcd = '0;
    logic [31:0] end_bcd = '0;
    logic [3:0]  stride = 4'd1;
    logic        stop = 1'b0;
    logic        cand_valid;
    logic        cand_ready = 1'b1;
    logic [63:0] cand_att;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] count;

    always #5 clk = ~clk;

    md5_cand_gen #(.NUM_DIGITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_bcd  (start_bcd),
        .end_bcd    (end_bcd),
        .stride     (stride),
        .stop       (stop),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .cand_att   (cand_att),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fails = 0;
    int          n_xfers = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [63:0] prev_att = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [63:0] ascii_of(input int unsigned v);
        logic [63:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8] = 8'h30 + 8'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] bcd_of(input int unsigned v);
        logic [31:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic expect_range(input int unsigned s, input int unsigned e, input int unsigned st,
                                input int max_n, output int n);
        int unsigned v;
        int unsigned step;
        v    = s;
        step = (st == 0) ? 1 : st;
        n    = 0;
        while (1'b1) begin
            exp_q.push_back(ascii_of(v));
            n++;
            if (n >= max_n || v >= e || v + step > 99999999) break;
            v = v + step;
        end
    endtask

    // Called and returns at posedge+2.
    task automatic pulse_start(input logic [31:0] s, input logic [31:0] e, input logic [3:0] st);
        start_bcd = s;
        end_bcd   = e;
        stride    = st;
        start     = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_count, output int cycles);
        cycles = 0;
        while (!done && cycles < 300) begin
            @(posedge clk); #2;
            cycles++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_count"}, 64'(count), 64'(exp_count));
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_range(input string tag, input int unsigned s, input int unsigned e,
                             input int unsigned st, output int cycles);
        int n;
        expect_range(s, e, st, 1000, n);
        pulse_start(bcd_of(s), bcd_of(e), 4'(st));
        wait_done(tag, n, cycles);
    endtask

    always @(negedge clk) begin
        if (cand_valid && prev_valid && !prev_ready) check("hold", cand_att, prev_att);
        if (cand_valid && cand_ready) begin
            if (exp_q.size() == 0) check("unexpected_cand", 64'(exp_q.size()), 64'd1);
            else check("cand", cand_att, exp_q.pop_front());
            n_xfers++;
        end
        prev_valid = cand_valid;
        prev_ready = cand_ready;
        prev_att   = cand_att;
    end

    initial begin
        int cyc;
        int n;
        int x0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", 64'(cand_valid), 64'd0);
        check("rst_att", cand_att, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        reset = 1'b0;
        @(posedge clk); #2;
        check("idle_valid", 64'(cand_valid), 64'd0);

        // 0..3 stride 1 at full throughput
        x0 = n_xfers;
        expect_range(0, 3, 1, 1000, n);
        pulse_start(32'h0000_0000, 32'h0000_0003, 4'd1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_first", cand_att, 64'h3030_3030_3030_3030);
        wait_done("t1", 4, cyc);
        check("t1_cycles", 64'(cyc), 64'd4);
        check("t1_xfers", 64'(n_xfers - x0), 64'd4);

        // Decimal carry across two digits
        run_range("t2", 98, 102, 1, cyc);

        // Overflow past 99999999 ends the run without wrapping
        run_range("t3", 99999997, 99999999, 3, cyc);

        // Stride 0 behaves as 1
        run_range("t_stride0", 5, 7, 0, cyc);

        // start > end emits only the start value
        run_range("t_rev", 50, 10, 1, cyc);

        // Backpressure: ready 1,0,0,1 while 10,15,15,15 are presented
        expect_range(10, 25, 5, 1000, n);
        cand_ready = 1'b1;
        pulse_start(32'h0000_0010, 32'h0000_0025, 4'd5);
        check("bp_c10", cand_att, ascii_of(10));
        @(posedge clk); #2;
        cand_ready = 1'b0;
        check("bp_c15a", cand_att, ascii_of(15));
        @(posedge clk); #2;
        check("bp_c15b", cand_att, ascii_of(15));
        @(posedge clk); #2;
        cand_ready = 1'b1;
        check("bp_c15c", cand_att, ascii_of(15));
        @(posedge clk); #2;
        check("bp_c20", cand_att, ascii_of(20));
        wait_done("bp", n, cyc);

        // stop coinciding with the third transfer
        expect_range(0, 20, 2, 3, n);
        pulse_start(32'h0000_0000, 32'h0000_0020, 4'd2);
        @(posedge clk); #2;
        @(posedge clk); #2;
        stop = 1'b1;
        @(posedge clk); #2;
        stop = 1'b0;
        check("stop_valid", 64'(cand_valid), 64'd0);
        check("stop_count", 64'(count), 64'd3);
        check("stop_done", 64'(done), 64'd1);
        check("stop_left", 64'(exp_q.size()), 64'd0);

        // Illegal digits in start_bcd, then in end_bcd
        pulse_start(32'h0000_000A, 32'h0000_0099, 4'd1);
        check("err_s_err", 64'(err), 64'd1);
        check("err_s_done", 64'(done), 64'd1);
        check("err_s_valid", 64'(cand_valid), 64'd0);
        check("err_s_busy", 64'(busy), 64'd0);
        @(posedge clk); #2;
        check("err_s_valid2", 64'(cand_valid), 64'd0);
        pulse_start(32'h0000_0000, 32'h0000_00F0, 4'd1);
        check("err_e_err", 64'(err), 64'd1);
        check("err_e_valid", 64'(cand_valid), 64'd0);

        // Reset in the middle of a run, then a clean restart
        expect_range(0, 50, 1, 1000, n);
        pulse_start(32'h0000_0000, 32'h0000_0050, 4'd1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        check("mrst_valid", 64'(cand_valid), 64'd0);
        check("mrst_att", cand_att, 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_err", 64'(err), 64'd0);
        check("mrst_count", 64'(count), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #2;
        run_range("restart", 7, 9, 1, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
